// File: rtl/falafel_mem_responder_if.sv
// rtl/falafel_mem_responder_if.sv - LSU memory port: request and response channels
interface falafel_mem_responder_if #(
  parameter int DATA_W = 64
);
  logic              mem_req_val;
  logic              mem_req_rdy;
  logic              mem_req_is_write;
  logic              mem_req_is_cas;
  logic [DATA_W-1:0] mem_req_addr;
  logic [DATA_W-1:0] mem_req_data;
  logic [DATA_W-1:0] mem_req_cas_exp;
  logic              mem_rsp_val;
  logic              mem_rsp_rdy;
  logic [DATA_W-1:0] mem_rsp_data;

  modport master (
    output mem_req_val, mem_req_is_write, mem_req_is_cas, mem_req_addr,
           mem_req_data, mem_req_cas_exp, mem_rsp_rdy,
    input  mem_req_rdy, mem_rsp_val, mem_rsp_data
  );

  modport slave (
    input  mem_req_val, mem_req_is_write, mem_req_is_cas, mem_req_addr,
           mem_req_data, mem_req_cas_exp, mem_rsp_rdy,
    output mem_req_rdy, mem_rsp_val, mem_rsp_data
  );
endinterface

// File: rtl/falafel_mem_responder.sv
// rtl/falafel_mem_responder.sv - atomic read/write/CAS SRAM responder with programmable latency
module falafel_mem_responder #(
  parameter int DATA_W  = 64,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  falafel_mem_responder_if.slave mem_if,
  input  logic                 dbg_we_i,
  input  logic [DATA_W-1:0]    dbg_addr_i,
  input  logic [DATA_W-1:0]    dbg_data_i,
  output logic                 oob_err_o,
  output logic [31:0]          cas_fail_cnt_o
);
  localparam int OFF_W = $clog2(DATA_W / 8);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              oob_q, oob_d;
  logic [31:0]       cas_cnt_q, cas_cnt_d;
  logic              rdy_en_q;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [DATA_W-1:0] req_word, dbg_word, rd_word;
  logic [IDX_W-1:0]  req_idx, dbg_idx;
  logic              req_oob, dbg_oob;
  logic              req_rdy, rsp_val, mem_we;

  assign req_word = mem_if.mem_req_addr >> OFF_W;
  assign req_oob  = req_word >= DATA_W'(DEPTH);
  assign req_idx  = req_word[IDX_W-1:0];
  assign dbg_word = dbg_addr_i >> OFF_W;
  assign dbg_oob  = dbg_word >= DATA_W'(DEPTH);
  assign dbg_idx  = dbg_word[IDX_W-1:0];
  assign rd_word  = mem_q[req_idx];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rsp_data_d = rsp_data_q;
    oob_d      = oob_q;
    cas_cnt_d  = cas_cnt_q;
    mem_we     = 1'b0;
    req_rdy    = 1'b0;
    rsp_val    = 1'b0;
    case (state_q)
      S_IDLE: begin
        // rdy_en_q keeps ready low for the first cycle after reset release
        req_rdy = !rst_i && rdy_en_q && !dbg_we_i;
        if (req_rdy && mem_if.mem_req_val) begin
          if (req_oob) begin
            rsp_data_d = '0;
            oob_d      = 1'b1;
          end else if (!mem_if.mem_req_is_write) begin
            rsp_data_d = rd_word;
          end else if (!mem_if.mem_req_is_cas) begin
            mem_we     = 1'b1;
            rsp_data_d = mem_if.mem_req_data;
          end else begin
            rsp_data_d = rd_word;
            if (rd_word == mem_if.mem_req_cas_exp) begin
              mem_we = 1'b1;
            end else if (cas_cnt_q != 32'hFFFF_FFFF) begin
              cas_cnt_d = cas_cnt_q + 32'd1;
            end
          end
          if (LATENCY == 1) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_W'(LATENCY - 1);
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RESP: begin
        rsp_val = 1'b1;
        if (mem_if.mem_rsp_rdy) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      rsp_data_q <= '0;
      oob_q      <= 1'b0;
      cas_cnt_q  <= '0;
      rdy_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rsp_data_q <= rsp_data_d;
      oob_q      <= oob_d;
      cas_cnt_q  <= cas_cnt_d;
      rdy_en_q   <= 1'b1;
    end
  end

  // Not reset; the request port is blocked whenever the backdoor writes
  always_ff @(posedge clk_i) begin
    if (dbg_we_i) begin
      if (!dbg_oob) begin
        mem_q[dbg_idx] <= dbg_data_i;
      end
    end else if (mem_we) begin
      mem_q[req_idx] <= mem_if.mem_req_data;
    end
  end

  assign mem_if.mem_req_rdy  = req_rdy;
  assign mem_if.mem_rsp_val  = rsp_val;
  assign mem_if.mem_rsp_data = rsp_data_q;
  assign oob_err_o           = oob_q;
  assign cas_fail_cnt_o      = cas_cnt_q;
endmodule

// File: tb/tb_falafel_mem_responder.sv
// tb/tb_falafel_mem_responder.sv - scoreboard bench for falafel_mem_responder
module tb_falafel_mem_responder;
  localparam int DW    = 64;
  localparam int DEPTH = 1024;
  localparam int LAT   = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          dbg_we;
  logic [DW-1:0] dbg_addr, dbg_data;
  logic          oob;
  logic [31:0]   cas_cnt;

  int            cmp_cnt = 0;
  int            err_cnt = 0;
  int            rsp_cnt = 0;
  logic [DW-1:0] exp_q [$];

  always #5 clk = ~clk;

  falafel_mem_responder_if #(.DATA_W(DW)) bus ();

  falafel_mem_responder #(.DATA_W(DW), .DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .mem_if         (bus),
    .dbg_we_i       (dbg_we),
    .dbg_addr_i     (dbg_addr),
    .dbg_data_i     (dbg_data),
    .oob_err_o      (oob),
    .cas_fail_cnt_o (cas_cnt)
  );

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every response handshake is matched against the scoreboard
  always @(negedge clk) begin
    if (!rst && bus.mem_rsp_val && bus.mem_rsp_rdy) begin
      if (exp_q.size() == 0) begin
        cmp_cnt++;
        err_cnt++;
        $display("FAIL unexpected_rsp: got 0x%0h expected no response", bus.mem_rsp_data);
      end else begin
        check("rsp_data", bus.mem_rsp_data, exp_q.pop_front());
      end
      rsp_cnt++;
    end
  end

  task automatic dbg_wr(input logic [DW-1:0] a, input logic [DW-1:0] d);
    @(posedge clk); #1;
    dbg_we = 1'b1; dbg_addr = a; dbg_data = d;
    @(posedge clk); #1;
    dbg_we = 1'b0;
  endtask

  task automatic do_req(input logic w, input logic c, input logic [DW-1:0] a,
                        input logic [DW-1:0] d, input logic [DW-1:0] e, input logic [DW-1:0] exp_rsp);
    int n = 0;
    @(negedge clk);
    while (!bus.mem_req_rdy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      check("req_rdy_timeout", 64'(bus.mem_req_rdy), 64'd1);
    end else begin
      bus.mem_req_val      = 1'b1;
      bus.mem_req_is_write = w;
      bus.mem_req_is_cas   = c;
      bus.mem_req_addr     = a;
      bus.mem_req_data     = d;
      bus.mem_req_cas_exp  = e;
      exp_q.push_back(exp_rsp);
      @(posedge clk); #1;
      bus.mem_req_val = 1'b0;
    end
  endtask

  task automatic wait_val(output int cyc);
    cyc = 0;
    while (cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (bus.mem_rsp_val) break;
    end
  endtask

  task automatic txn(input string name, input logic w, input logic c, input logic [DW-1:0] a,
                     input logic [DW-1:0] d, input logic [DW-1:0] e, input logic [DW-1:0] exp_rsp);
    int prev;
    int cyc;
    int n = 0;
    prev = rsp_cnt;
    do_req(w, c, a, d, e, exp_rsp);
    wait_val(cyc);
    check({name, "_latency"}, 64'(cyc), 64'(LAT));
    while (rsp_cnt == prev && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    if (n >= 20) check({name, "_rsp_timeout"}, 64'(rsp_cnt), 64'(prev + 1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] held;
    logic [DW-1:0] dummy;
    int prev;
    int cyc;

    rst = 1'b1; dbg_we = 1'b0; dbg_addr = '0; dbg_data = '0;
    bus.mem_req_val = 1'b0; bus.mem_req_is_write = 1'b0; bus.mem_req_is_cas = 1'b0;
    bus.mem_req_addr = '0; bus.mem_req_data = '0; bus.mem_req_cas_exp = '0;
    bus.mem_rsp_rdy = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_rdy", 64'(bus.mem_req_rdy), 64'd0);
    check("rst_rsp_val", 64'(bus.mem_rsp_val), 64'd0);
    check("rst_rsp_data", bus.mem_rsp_data, 64'd0);
    check("rst_oob", 64'(oob), 64'd0);
    check("rst_cas_cnt", 64'(cas_cnt), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rdy_first_cycle", 64'(bus.mem_req_rdy), 64'd0);
    @(negedge clk);
    check("rdy_after_reset", 64'(bus.mem_req_rdy), 64'd1);

    // Backdoor preload; ready must drop while the backdoor is active
    @(posedge clk); #1;
    dbg_we = 1'b1; dbg_addr = 64'h20; dbg_data = 64'hAA;
    @(negedge clk);
    check("rdy_blocked_dbg", 64'(bus.mem_req_rdy), 64'd0);
    @(posedge clk); #1;
    dbg_we = 1'b0;
    dbg_wr(64'h10, 64'd5);
    dbg_wr(64'h0, 64'h77);

    txn("read_preload", 1'b0, 1'b0, 64'h20, 64'h0, 64'h0, 64'hAA);
    txn("write_8", 1'b1, 1'b0, 64'h8, 64'h1234, 64'h0, 64'h1234);
    txn("read_8", 1'b0, 1'b0, 64'h8, 64'h0, 64'h0, 64'h1234);

    txn("cas_hit", 1'b1, 1'b1, 64'h10, 64'd9, 64'd5, 64'd5);
    txn("read_cas", 1'b0, 1'b0, 64'h10, 64'h0, 64'h0, 64'd9);
    txn("cas_miss", 1'b1, 1'b1, 64'h10, 64'd7, 64'd5, 64'd9);
    txn("read_cas2", 1'b0, 1'b0, 64'h10, 64'h0, 64'h0, 64'd9);
    check("cas_fail_cnt", 64'(cas_cnt), 64'd1);

    // Response back-pressure
    prev = rsp_cnt;
    bus.mem_rsp_rdy = 1'b0;
    do_req(1'b0, 1'b0, 64'h8, 64'h0, 64'h0, 64'h1234);
    wait_val(cyc);
    check("hold_latency", 64'(cyc), 64'(LAT));
    held = bus.mem_rsp_data;
    check("hold_data_first", held, 64'h1234);
    repeat (5) begin
      @(negedge clk);
      check("hold_val", 64'(bus.mem_rsp_val), 64'd1);
      check("hold_data", bus.mem_rsp_data, held);
      check("hold_req_rdy", 64'(bus.mem_req_rdy), 64'd0);
    end
    @(posedge clk); #1;
    bus.mem_rsp_rdy = 1'b1;
    @(posedge clk); #1;
    check("hold_released", 64'(bus.mem_rsp_val), 64'd0);
    check("hold_rsp_count", 64'(rsp_cnt), 64'(prev + 1));
    @(negedge clk);
    check("hold_rdy_back", 64'(bus.mem_req_rdy), 64'd1);

    // Out-of-range backdoor is dropped silently; must not alias word 0
    dbg_wr(64'(DEPTH * 8), 64'h55);
    check("dbg_oob_no_flag", 64'(oob), 64'd0);
    txn("read_w0_a", 1'b0, 1'b0, 64'h0, 64'h0, 64'h0, 64'h77);

    txn("oob_read", 1'b0, 1'b0, 64'(DEPTH * 8), 64'h0, 64'h0, 64'h0);
    check("oob_set", 64'(oob), 64'd1);
    txn("oob_write", 1'b1, 1'b0, 64'(DEPTH * 8), 64'hDEAD, 64'h0, 64'h0);
    check("oob_sticky", 64'(oob), 64'd1);
    txn("read_w0_b", 1'b0, 1'b0, 64'h0, 64'h0, 64'h0, 64'h77);
    txn("read_8_b", 1'b0, 1'b0, 64'h8, 64'h0, 64'h0, 64'h1234);
    txn("read_20_b", 1'b0, 1'b0, 64'h20, 64'h0, 64'h0, 64'hAA);

    // Reset while the write response is pending
    prev = rsp_cnt;
    do_req(1'b1, 1'b0, 64'h18, 64'hBEEF, 64'h0, 64'hBEEF);
    rst = 1'b1;
    dummy = exp_q.pop_back();
    @(negedge clk);
    check("rstw_req_rdy", 64'(bus.mem_req_rdy), 64'd0);
    check("rstw_rsp_val", 64'(bus.mem_rsp_val), 64'd0);
    @(negedge clk);
    check("rstw_rsp_data", bus.mem_rsp_data, 64'd0);
    check("rstw_oob", 64'(oob), 64'd0);
    check("rstw_cas_cnt", 64'(cas_cnt), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rstw_rdy_low", 64'(bus.mem_req_rdy), 64'd0);
    @(negedge clk);
    check("rstw_rdy_high", 64'(bus.mem_req_rdy), 64'd1);
    repeat (4) @(negedge clk);
    check("rstw_no_rsp", 64'(rsp_cnt), 64'(prev));
    txn("read_18", 1'b0, 1'b0, 64'h18, 64'h0, 64'h0, 64'hBEEF);

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end
endmodule
